// File: rtl/exe_stage_pkg.sv
// Shared types and field indices for the execute stage and its iterative divider.
package exe_stage_pkg;

  localparam int unsigned DS_TO_ES_W = 175;
  localparam int unsigned ES_TO_MS_W = 78;
  localparam int unsigned BR_W       = 33;
  localparam int unsigned ES_TO_FW_W = 39;

  localparam int unsigned OP_ADD    = 0;
  localparam int unsigned OP_SUB    = 1;
  localparam int unsigned OP_SLT    = 2;
  localparam int unsigned OP_SLTU   = 3;
  localparam int unsigned OP_AND    = 4;
  localparam int unsigned OP_NOR    = 5;
  localparam int unsigned OP_OR     = 6;
  localparam int unsigned OP_XOR    = 7;
  localparam int unsigned OP_SLL    = 8;
  localparam int unsigned OP_SRL    = 9;
  localparam int unsigned OP_SRA    = 10;
  localparam int unsigned OP_LUI    = 11;
  localparam int unsigned OP_MUL    = 12;
  localparam int unsigned OP_MULH   = 13;
  localparam int unsigned OP_MULHU  = 14;
  localparam int unsigned OP_DIVW   = 15;
  localparam int unsigned OP_MODW   = 16;
  localparam int unsigned OP_DIVWU  = 17;
  localparam int unsigned OP_MODWU  = 18;

  localparam int unsigned BR_BEQ  = 0;
  localparam int unsigned BR_BNE  = 1;
  localparam int unsigned BR_BLT  = 2;
  localparam int unsigned BR_BGE  = 3;
  localparam int unsigned BR_BLTU = 4;
  localparam int unsigned BR_BGEU = 5;
  localparam int unsigned BR_B    = 6;
  localparam int unsigned BR_BL   = 7;
  localparam int unsigned BR_JIRL = 8;

  localparam int unsigned ST_B = 0;
  localparam int unsigned ST_H = 1;
  localparam int unsigned ST_W = 2;

  typedef struct packed {
    logic [18:0] alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_4;
    logic        mem_to_reg;
    logic        reg_we;
    logic        mem_we;
    logic [4:0]  load_op;
    logic [2:0]  store_op;
    logic [8:0]  branch_op;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] pc;
  } ds_bus_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  function automatic logic [31:0] lane_wdata(input logic [2:0] store_op, input logic [31:0] data);
    if (store_op[ST_B]) return {4{data[7:0]}};
    if (store_op[ST_H]) return {2{data[15:0]}};
    return data;
  endfunction

endpackage

// File: rtl/exe_stage_div_iter.sv
// Restoring radix-2 divider: latches operands on start, one quotient bit per cycle.
module div_iter #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      quo, rem, divisor, abs_x, abs_y;
  logic [32:0]      shifted, diff;
  logic             neg_q, neg_r;

  always_comb begin
    abs_x   = (sign && x[31]) ? -x : x;
    abs_y   = (sign && y[31]) ? -y : y;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, divisor};
  end

  // done marks the final iteration; q/r are settled from the following cycle on
  assign done = busy && (cnt == CNT_W'(DIV_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= '0;
      quo     <= abs_x;
      rem     <= '0;
      divisor <= abs_y;
      neg_q   <= sign && (x[31] ^ y[31]) && (y != '0);
      neg_r   <= sign && x[31];
    end else if (busy) begin
      if (diff[32]) begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end else begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end
      cnt <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

  assign q = neg_q ? -quo : quo;
  assign r = neg_r ? -rem : rem;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, multiply, iterative divide, branch resolution, data-SRAM request.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned RESET_PC_HI = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ms_allowin,
  output logic                  es_allowin,
  input  logic                  ds_to_es_valid,
  input  logic [DS_TO_ES_W-1:0] ds_to_es_bus,
  output logic                  es_to_ms_valid,
  output logic [ES_TO_MS_W-1:0] es_to_ms_bus,
  output logic [BR_W-1:0]       br_bus,
  output logic [ES_TO_FW_W-1:0] es_to_fw_bus,
  output logic                  data_sram_en,
  output logic [3:0]            data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata
);

  ds_bus_t     ds;
  div_state_t  div_state;
  logic        es_valid, es_ready_go;
  logic        div_op, div_sign, div_start, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [31:0] src1, src2, sra_res, alu_result, result;
  logic        ext1, ext2;
  logic [63:0] prod;
  logic        eq, lt_s, lt_u, br_cond, br_taken;
  logic [31:0] br_target, mem_addr;
  logic [3:0]  st_mask;

  assign div_op         = |ds.alu_op[OP_MODWU:OP_DIVW];
  assign es_ready_go    = !div_op || (div_state == DIV_DONE);
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      es_valid <= 1'b0;
      ds       <= '0;
      ds.pc    <= {16'(RESET_PC_HI), 16'h0};
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) ds <= ds_to_es_bus;
    end
  end

  assign div_sign  = ds.alu_op[OP_DIVW] || ds.alu_op[OP_MODW];
  assign div_start = es_valid && div_op && (div_state == DIV_IDLE) && !div_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_state <= DIV_IDLE;
    end else begin
      case (div_state)
        DIV_IDLE: if (div_start) div_state <= DIV_BUSY;
        DIV_BUSY: if (div_done) div_state <= DIV_DONE;
        DIV_DONE: if (es_to_ms_valid && ms_allowin) div_state <= DIV_IDLE;
        default:  div_state <= DIV_IDLE;
      endcase
    end
  end

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .sign  (div_sign),
    .x     (ds.rdata1),
    .y     (ds.rdata2),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  // One 33x33 signed multiplier serves all three multiply flavours
  always_comb begin
    src1    = ds.src1_is_pc ? ds.pc : ds.rdata1;
    src2    = ds.src2_is_4 ? 32'd4 : (ds.src2_is_imm ? ds.imm : ds.rdata2);
    ext1    = ds.alu_op[OP_MULH] && src1[31];
    ext2    = ds.alu_op[OP_MULH] && src2[31];
    prod    = 64'($signed({ext1, src1})) * 64'($signed({ext2, src2}));
    sra_res = $signed(src1) >>> src2[4:0];
    alu_result = '0;
    if (ds.alu_op[OP_ADD])   alu_result |= src1 + src2;
    if (ds.alu_op[OP_SUB])   alu_result |= src1 - src2;
    if (ds.alu_op[OP_SLT])   alu_result |= {31'b0, $signed(src1) < $signed(src2)};
    if (ds.alu_op[OP_SLTU])  alu_result |= {31'b0, src1 < src2};
    if (ds.alu_op[OP_AND])   alu_result |= src1 & src2;
    if (ds.alu_op[OP_NOR])   alu_result |= ~(src1 | src2);
    if (ds.alu_op[OP_OR])    alu_result |= src1 | src2;
    if (ds.alu_op[OP_XOR])   alu_result |= src1 ^ src2;
    if (ds.alu_op[OP_SLL])   alu_result |= src1 << src2[4:0];
    if (ds.alu_op[OP_SRL])   alu_result |= src1 >> src2[4:0];
    if (ds.alu_op[OP_SRA])   alu_result |= sra_res;
    if (ds.alu_op[OP_LUI])   alu_result |= src2;
    if (ds.alu_op[OP_MUL])   alu_result |= prod[31:0];
    if (ds.alu_op[OP_MULH] || ds.alu_op[OP_MULHU]) alu_result |= prod[63:32];
    if (ds.alu_op[OP_DIVW] || ds.alu_op[OP_DIVWU]) result = div_q;
    else if (ds.alu_op[OP_MODW] || ds.alu_op[OP_MODWU]) result = div_r;
    else result = alu_result;
  end

  assign eq   = ds.rdata1 == ds.rdata2;
  assign lt_s = $signed(ds.rdata1) < $signed(ds.rdata2);
  assign lt_u = ds.rdata1 < ds.rdata2;

  assign br_cond = (ds.branch_op[BR_BEQ]  && eq)    || (ds.branch_op[BR_BNE]  && !eq)   ||
                   (ds.branch_op[BR_BLT]  && lt_s)  || (ds.branch_op[BR_BGE]  && !lt_s) ||
                   (ds.branch_op[BR_BLTU] && lt_u)  || (ds.branch_op[BR_BGEU] && !lt_u) ||
                   ds.branch_op[BR_B] || ds.branch_op[BR_BL] || ds.branch_op[BR_JIRL];
  assign br_target = ds.branch_op[BR_JIRL] ? ds.rdata1 + ds.imm : ds.pc + ds.imm;
  assign br_taken  = es_valid && br_cond && es_ready_go;
  assign br_bus    = {br_taken, br_target};

  assign mem_addr = ds.rdata1 + ds.imm;

  always_comb begin
    st_mask = '0;
    if (ds.store_op[ST_B])      st_mask = 4'b0001 << mem_addr[1:0];
    else if (ds.store_op[ST_H]) st_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
    else if (ds.store_op[ST_W]) st_mask = 4'b1111;
  end

  assign data_sram_en    = es_valid && (ds.mem_to_reg || ds.mem_we) && ms_allowin;
  assign data_sram_we    = (es_valid && ds.mem_we) ? st_mask : 4'b0000;
  assign data_sram_addr  = mem_addr;
  assign data_sram_wdata = lane_wdata(ds.store_op, ds.rdata2);

  assign es_to_ms_bus = {ds.load_op, ds.mem_to_reg, ds.reg_we, ds.dest, mem_addr[1:0], result, ds.pc};
  assign es_to_fw_bus = {es_valid && ds.reg_we, ds.mem_to_reg, ds.dest, result};

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against a plain-arithmetic reference model.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset, ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid, data_sram_en;
  logic [174:0] ds_to_es_bus;
  logic [77:0]  es_to_ms_bus;
  logic [32:0]  br_bus;
  logic [38:0]  es_to_fw_bus;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  always #5 clk = ~clk;

  exe_stage #(.DIV_CYCLES(32), .RESET_PC_HI(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .br_bus          (br_bus),
    .es_to_fw_bus    (es_to_fw_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  // Decode bus: op < 0 means no ALU op selected
  function automatic logic [174:0] mk(input int op, input logic [31:0] r1, r2, imm, pc,
                                      input logic use_imm, input logic [8:0] br,
                                      input logic mem_we, input logic [2:0] st, input logic [4:0] dest);
    logic [18:0] aop;
    aop = '0;
    if (op >= 0) aop[op] = 1'b1;
    return {aop, 1'b0, use_imm, 1'b0, 1'b0, (br == 9'h0) && !mem_we, mem_we, 5'h0, st, br, dest,
            imm, r1, r2, pc};
  endfunction

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return {31'b0, sa < sb};
      3:  return {31'b0, ua < ub};
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return 32'(sa >>> b[4:0]);
      11: return b;
      12: return 32'(sa * sb);
      13: return 32'((sa * sb) >>> 32);
      14: return 32'((ua * ub) >> 32);
      15: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      16: return (b == 0) ? a : 32'(sa % sb);
      17: return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  task automatic issue(input logic [174:0] bus);
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = bus;
    @(negedge clk);
    ds_to_es_valid = 1'b0;
  endtask

  task automatic run_div(input int op, input logic [31:0] a, b,
                         output int lat, output logic [31:0] res, output logic stall_ok);
    issue(mk(op, a, b, 32'h0, 32'h1C000000, 1'b0, 9'h0, 1'b0, 3'h0, 5'd7));
    lat = 0;
    stall_ok = 1'b1;
    while (!es_to_ms_valid && lat < 200) begin
      if (es_allowin !== 1'b0 || es_to_fw_bus[38] !== 1'b1) stall_ok = 1'b0;
      lat++;
      @(negedge clk);
    end
    res = es_to_ms_bus[63:32];
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++;
    if ({es_to_ms_valid, es_to_ms_bus, br_bus, es_to_fw_bus, data_sram_en, data_sram_we} !== '0 ||
        es_allowin !== 1'b1) begin
      $display("FAIL reset_state: valid=%b ms=%h br=%h fw=%h en=%b we=%b allowin=%b required all 0, allowin 1",
               es_to_ms_valid, es_to_ms_bus, br_bus, es_to_fw_bus, data_sram_en, data_sram_we, es_allowin);
    end else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = mk(0, 32'd7, 32'hFFFFFFFD, 32'h0, 32'h1C000100, 1'b0, 9'h0, 1'b0, 3'h0, 5'd4);
    @(negedge clk);
    total_cnt++;
    if (es_to_fw_bus !== {1'b1, 1'b0, 5'd4, 32'd4} || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1 ||
        es_to_ms_bus[31:0] !== 32'h1C000100) begin
      $display("FAIL add_fwd: fw=%h valid=%b allowin=%b pc=%h required fw=%h valid 1 allowin 1 pc 1c000100",
               es_to_fw_bus, es_to_ms_valid, es_allowin, es_to_ms_bus[31:0], {1'b1, 1'b0, 5'd4, 32'd4});
    end else pass_cnt++;
    ds_to_es_bus = mk(2, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h1C000104, 1'b0, 9'h0, 1'b0, 3'h0, 5'd5);
    @(negedge clk);
    ds_to_es_valid = 1'b0;
    total_cnt++;
    if (es_to_fw_bus !== {1'b1, 1'b0, 5'd5, 32'd1} || es_to_ms_bus[63:32] !== 32'd1) begin
      $display("FAIL slt_fwd: fw=%h result=%h required fw=%h result 1",
               es_to_fw_bus, es_to_ms_bus[63:32], {1'b1, 1'b0, 5'd5, 32'd1});
    end else pass_cnt++;
  endtask

  task automatic test_alu;
    int op;
    logic [31:0] a, b, expv;
    logic use_imm;
    for (int i = 0; i < 45; i++) begin
      op = (i < 15) ? i : int'($urandom_range(0, 14));
      a = $urandom;
      b = $urandom;
      use_imm = 1'($urandom_range(0, 1));
      expv = ref_alu(op, a, b);
      issue(mk(op, a, use_imm ? ~b : b, use_imm ? b : ~b, 32'h1C000200, use_imm, 9'h0, 1'b0, 3'h0, 5'd3));
      total_cnt++;
      if ({es_to_ms_valid, es_to_ms_bus[63:32]} !== {1'b1, expv}) begin
        $display("FAIL alu_op%0d a=%h b=%h: valid=%b result=%h required %h",
                 op, a, b, es_to_ms_valid, es_to_ms_bus[63:32], expv);
      end else pass_cnt++;
    end
  endtask

  task automatic test_div;
    int lat, op;
    logic [31:0] res, a, b, expv;
    logic stall_ok;
    run_div(15, 32'hFFFFFFF9, 32'd2, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'hFFFFFFFD || lat !== 33 || stall_ok !== 1'b1) begin
      $display("FAIL div_w_neg7_2: q=%h lat=%0d stall_ok=%b required q=fffffffd lat=33 stall_ok=1",
               res, lat, stall_ok);
    end else pass_cnt++;
    run_div(16, 32'hFFFFFFF9, 32'd2, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'hFFFFFFFF || lat !== 33 || stall_ok !== 1'b1) begin
      $display("FAIL mod_w_neg7_2: r=%h lat=%0d stall_ok=%b required r=ffffffff lat=33 stall_ok=1",
               res, lat, stall_ok);
    end else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      op = int'($urandom_range(15, 18));
      a = $urandom;
      b = (i == 3) ? 32'h0 : ((i % 2 == 0) ? ($urandom >> $urandom_range(0, 28)) : $urandom);
      expv = ref_alu(op, a, b);
      run_div(op, a, b, lat, res, stall_ok);
      total_cnt++;
      if (res !== expv || lat !== 33 || stall_ok !== 1'b1) begin
        $display("FAIL div_rand op%0d a=%h b=%h: res=%h lat=%0d stall_ok=%b required %h lat=33",
                 op, a, b, res, lat, stall_ok, expv);
      end else pass_cnt++;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [31:0] res;
    logic stall_ok;
    run_div(17, 32'd5, 32'd0, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'hFFFFFFFF || lat !== 33) begin
      $display("FAIL divwu_by0: q=%h lat=%0d required q=ffffffff lat=33", res, lat);
    end else pass_cnt++;
    run_div(18, 32'd5, 32'd0, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'd5 || lat !== 33) begin
      $display("FAIL modwu_by0: r=%h lat=%0d required r=5 lat=33", res, lat);
    end else pass_cnt++;
    run_div(15, 32'hFFFFFFFB, 32'd0, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'hFFFFFFFF) begin
      $display("FAIL divw_neg_by0: q=%h required ffffffff", res);
    end else pass_cnt++;
  endtask

  task automatic test_branch;
    logic [31:0] a, b, pc, imm;
    int k;
    logic taken;
    issue(mk(-1, 32'h55, 32'h55, 32'h20, 32'h1C000010, 1'b0, 9'b000000001, 1'b0, 3'h0, 5'd0));
    total_cnt++;
    if (br_bus !== {1'b1, 32'h1C000030}) begin
      $display("FAIL beq_taken: br_bus=%h required %h", br_bus, {1'b1, 32'h1C000030});
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (br_bus[32] !== 1'b0) $display("FAIL beq_one_cycle: br_taken=%b required 0", br_bus[32]);
    else pass_cnt++;
    issue(mk(-1, 32'h55, 32'h55, 32'h20, 32'h1C000010, 1'b0, 9'b000000010, 1'b0, 3'h0, 5'd0));
    total_cnt++;
    if (br_bus[32] !== 1'b0) $display("FAIL bne_not_taken: br_taken=%b required 0", br_bus[32]);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      k = int'($urandom_range(0, 8));
      a = $urandom;
      b = (i % 3 == 0) ? a : $urandom;
      pc = $urandom;
      imm = $urandom;
      case (k)
        0: taken = (a == b);
        1: taken = (a != b);
        2: taken = ($signed(a) < $signed(b));
        3: taken = ($signed(a) >= $signed(b));
        4: taken = (a < b);
        5: taken = (a >= b);
        default: taken = 1'b1;
      endcase
      issue(mk(-1, a, b, imm, pc, 1'b0, 9'(1 << k), 1'b0, 3'h0, 5'd0));
      total_cnt++;
      if (br_bus !== {taken, (k == 8) ? a + imm : pc + imm}) begin
        $display("FAIL branch_rand k=%0d a=%h b=%h: br_bus=%h required %h",
                 k, a, b, br_bus, {taken, (k == 8) ? a + imm : pc + imm});
      end else pass_cnt++;
    end
  endtask

  task automatic test_store;
    issue(mk(-1, 32'h1000, 32'h123456AB, 32'h3, 32'h1C000300, 1'b0, 9'h0, 1'b1, 3'b001, 5'd0));
    total_cnt++;
    if ({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b1000, 32'h1003, 32'hABABABAB}) begin
      $display("FAIL st_b: en=%b we=%b addr=%h wdata=%h required en=1 we=1000 addr=1003 wdata=abababab",
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata);
    end else pass_cnt++;
    ms_allowin = 1'b0;
    issue(mk(-1, 32'h1000, 32'h123456AB, 32'h3, 32'h1C000300, 1'b0, 9'h0, 1'b1, 3'b001, 5'd0));
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (data_sram_en !== 1'b0 || es_allowin !== 1'b0) begin
        $display("FAIL st_b_blocked cyc%0d: en=%b allowin=%b required 0 0", i, data_sram_en, es_allowin);
      end else pass_cnt++;
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    total_cnt++;
    if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1000) begin
      $display("FAIL st_b_released: en=%b we=%b required en=1 we=1000", data_sram_en, data_sram_we);
    end else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (data_sram_en !== 1'b0) $display("FAIL st_b_retired: en=%b required 0", data_sram_en);
    else pass_cnt++;
    issue(mk(-1, 32'h2000, 32'h7777BEEF, 32'h2, 32'h1C000304, 1'b0, 9'h0, 1'b1, 3'b010, 5'd0));
    total_cnt++;
    if ({data_sram_we, data_sram_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
      $display("FAIL st_h: we=%b wdata=%h required we=1100 wdata=beefbeef", data_sram_we, data_sram_wdata);
    end else pass_cnt++;
    issue(mk(-1, 32'h3000, 32'hCAFEF00D, 32'h0, 32'h1C000308, 1'b0, 9'h0, 1'b1, 3'b100, 5'd0));
    total_cnt++;
    if ({data_sram_we, data_sram_wdata} !== {4'b1111, 32'hCAFEF00D}) begin
      $display("FAIL st_w: we=%b wdata=%h required we=1111 wdata=cafef00d", data_sram_we, data_sram_wdata);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_div;
    int lat;
    logic [31:0] res;
    logic stall_ok;
    issue(mk(15, 32'd1000, 32'd3, 32'h0, 32'h1C000400, 1'b0, 9'h0, 1'b0, 3'h0, 5'd7));
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    total_cnt++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || es_to_fw_bus[38] !== 1'b0) begin
      $display("FAIL reset_mid_div: valid=%b allowin=%b fw_valid=%b required 0 1 0",
               es_to_ms_valid, es_allowin, es_to_fw_bus[38]);
    end else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    run_div(15, 32'd100, 32'd7, lat, res, stall_ok);
    total_cnt++;
    if (res !== 32'd14 || lat !== 33 || stall_ok !== 1'b1) begin
      $display("FAIL div_after_reset: q=%h lat=%0d stall_ok=%b required q=e lat=33 stall_ok=1",
               res, lat, stall_ok);
    end else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    ms_allowin     = 1'b1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_alu();
    test_div();
    test_div_zero();
    test_branch();
    test_store();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
